// File: rtl/iiq_pkg.sv
// Shared types for the issue-queue select block: wakeup tag, per-entry tracking
// state and the wakeup broadcast port count.
package iiq_pkg;

  localparam int IIQ_TAG_WIDTH  = 6;
  localparam int IIQ_WAKE_PORTS = 2;

  typedef logic [IIQ_TAG_WIDTH-1:0] tag_t;
  typedef tag_t [IIQ_WAKE_PORTS-1:0] wake_tags_t;

  typedef struct packed {
    logic valid;
    logic rdy1;
    logic rdy2;
    tag_t tag1;
    tag_t tag2;
  } iiq_entry_t;

  function automatic logic wake_hit(tag_t tag, logic [IIQ_WAKE_PORTS-1:0] wvld, wake_tags_t wtag);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < IIQ_WAKE_PORTS; p++) begin
      hit = hit | (wvld[p] & (wtag[p] == tag));
    end
    return hit;
  endfunction

endpackage

// File: rtl/lsb_onehot_picker.sv
// Lowest-set-bit picker: purely combinational, returns a one-hot grant or zero.
// No state, no backpressure; the caller qualifies the grant.
module lsb_onehot_picker #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  assign gnt = req & (~req + N'(1));

endmodule

// File: rtl/iiq_issue_select.sv
// Ready-tracking and oldest-ready select for a shift issue queue; issue register latency 1,
// dequeue stalls while the held issue is not accepted. IIQ_WAKEUP_BYPASS_EN enables same-cycle wakeup select.
module iiq_issue_select
  import iiq_pkg::*;
#(
  parameter int N_ENTRIES   = 8,
  parameter int ENTRY_WIDTH = 64,
  parameter int TAG_WIDTH   = IIQ_TAG_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_aL,
  input  logic                                flush,
  input  logic                                alloc_valid,
  output logic                                alloc_ready,
  input  logic [TAG_WIDTH-1:0]                alloc_src1_tag,
  input  logic [TAG_WIDTH-1:0]                alloc_src2_tag,
  input  logic                                alloc_src1_rdy,
  input  logic                                alloc_src2_rdy,
  input  logic [IIQ_WAKE_PORTS-1:0]           wakeup_valid,
  input  logic [IIQ_WAKE_PORTS*TAG_WIDTH-1:0] wakeup_tag,
  output logic [N_ENTRIES-1:0]                deq_sel_onehot,
  output logic                                deq_ready,
  input  logic [ENTRY_WIDTH-1:0]              deq_data,
  output logic                                issue_valid,
  output logic [ENTRY_WIDTH-1:0]              issue_data,
  input  logic                                issue_ready,
  output logic [$clog2(N_ENTRIES):0]          occupancy
);

  localparam int OCC_W = $clog2(N_ENTRIES) + 1;
  typedef logic [OCC_W-1:0] occ_t;

  iiq_entry_t [N_ENTRIES-1:0] ent_q;
  iiq_entry_t [N_ENTRIES-1:0] ent_d;
  iiq_entry_t [N_ENTRIES:0]   woke;
  iiq_entry_t                 new_ent;
  wake_tags_t                 wtag;
  logic [N_ENTRIES-1:0]       hit1, hit2, cand, pick;
  logic                       armed_q;
  logic                       alloc_take;
  logic                       seen;
  occ_t                       wr_idx;
  occ_t                       occ_d;

  always_comb begin
    for (int p = 0; p < IIQ_WAKE_PORTS; p++) begin
      wtag[p] = tag_t'(wakeup_tag[p*TAG_WIDTH +: TAG_WIDTH]);
    end
  end

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    cand = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      hit1[i] = wake_hit(ent_q[i].tag1, wakeup_valid, wtag);
      hit2[i] = wake_hit(ent_q[i].tag2, wakeup_valid, wtag);
`ifdef IIQ_WAKEUP_BYPASS_EN
      cand[i] = ent_q[i].valid & (ent_q[i].rdy1 | hit1[i]) & (ent_q[i].rdy2 | hit2[i]);
`else
      cand[i] = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
`endif
    end
  end

  lsb_onehot_picker #(.N(N_ENTRIES)) u_pick (
    .req (cand),
    .gnt (pick)
  );

  // armed_q holds everything idle across the first edge after reset release.
  assign deq_ready      = armed_q & (|pick) & (~issue_valid | issue_ready) & ~flush;
  assign deq_sel_onehot = deq_ready ? pick : '0;
  assign alloc_ready    = (occupancy < occ_t'(N_ENTRIES)) | deq_ready;

  always_comb begin
    alloc_take = armed_q & alloc_valid & alloc_ready & ~flush;
    wr_idx     = occupancy - occ_t'(deq_ready);

    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.tag1  = tag_t'(alloc_src1_tag);
    new_ent.tag2  = tag_t'(alloc_src2_tag);
    new_ent.rdy1  = alloc_src1_rdy | wake_hit(tag_t'(alloc_src1_tag), wakeup_valid, wtag);
    new_ent.rdy2  = alloc_src2_rdy | wake_hit(tag_t'(alloc_src2_tag), wakeup_valid, wtag);

    woke = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      woke[i]      = ent_q[i];
      woke[i].rdy1 = ent_q[i].rdy1 | (ent_q[i].valid & hit1[i]);
      woke[i].rdy2 = ent_q[i].rdy2 | (ent_q[i].valid & hit2[i]);
    end

    // Entries at or above the selected slot move down one; woke[N] supplies the empty top.
    seen  = 1'b0;
    ent_d = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      seen     = seen | deq_sel_onehot[i];
      ent_d[i] = seen ? woke[i+1] : woke[i];
      if (alloc_take && (wr_idx == occ_t'(i))) begin
        ent_d[i] = new_ent;
      end
    end
    if (flush) begin
      ent_d = '0;
    end

    occ_d = flush ? '0 : (occupancy + occ_t'(alloc_take) - occ_t'(deq_ready));
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      armed_q     <= 1'b0;
      ent_q       <= '0;
      occupancy   <= '0;
      issue_valid <= 1'b0;
      issue_data  <= '0;
    end else begin
      armed_q <= 1'b1;
      if (armed_q) begin
        ent_q     <= ent_d;
        occupancy <= occ_d;
        if (flush) begin
          issue_valid <= 1'b0;
        end else if (deq_ready) begin
          issue_valid <= 1'b1;
          issue_data  <= deq_data;
        end else if (issue_ready) begin
          issue_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_iiq_issue_select.sv
// Directed bench for iiq_issue_select (N_ENTRIES=4) with a small shift-queue model
// supplying deq_data and a scoreboard of expected issue payloads.
module tb_iiq_issue_select;

  localparam int N  = 4;
  localparam int EW = 64;
  localparam int TW = 6;

  logic            clk = 1'b0;
  logic            rst_aL;
  logic            flush;
  logic            alloc_valid;
  logic            alloc_ready;
  logic [TW-1:0]   alloc_src1_tag, alloc_src2_tag;
  logic            alloc_src1_rdy, alloc_src2_rdy;
  logic [1:0]      wakeup_valid;
  logic [2*TW-1:0] wakeup_tag;
  logic [N-1:0]    deq_sel_onehot;
  logic            deq_ready;
  logic [EW-1:0]   deq_data;
  logic            issue_valid;
  logic [EW-1:0]   issue_data;
  logic            issue_ready;
  logic [2:0]      occupancy;

  logic [EW-1:0]   alloc_pay;
  logic [EW-1:0]   qm [N];
  int              qcnt;
  logic [EW-1:0]   exp_q [$];
  int              vectors = 0;
  int              miscompares = 0;

  always #5 clk = ~clk;

  iiq_issue_select #(
    .N_ENTRIES   (N),
    .ENTRY_WIDTH (EW),
    .TAG_WIDTH   (TW)
  ) dut (
    .clk            (clk),
    .rst_aL         (rst_aL),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_src1_tag (alloc_src1_tag),
    .alloc_src2_tag (alloc_src2_tag),
    .alloc_src1_rdy (alloc_src1_rdy),
    .alloc_src2_rdy (alloc_src2_rdy),
    .wakeup_valid   (wakeup_valid),
    .wakeup_tag     (wakeup_tag),
    .deq_sel_onehot (deq_sel_onehot),
    .deq_ready      (deq_ready),
    .deq_data       (deq_data),
    .issue_valid    (issue_valid),
    .issue_data     (issue_data),
    .issue_ready    (issue_ready),
    .occupancy      (occupancy)
  );

  // Companion shift queue: returns the payload at the selected slot.
  always_comb begin
    deq_data = '0;
    for (int i = 0; i < N; i++) begin
      if (deq_sel_onehot[i]) deq_data = qm[i];
    end
  end

  always @(posedge clk) begin
    logic [EW-1:0] t [N];
    int n;
    t = qm;
    n = qcnt;
    if (rst_aL !== 1'b1 || flush) begin
      n = 0;
      for (int i = 0; i < N; i++) t[i] = '0;
    end else begin
      if (deq_ready) begin
        for (int i = 0; i < N; i++) begin
          if (deq_sel_onehot[i]) begin
            for (int j = i; j < N-1; j++) t[j] = t[j+1];
            t[N-1] = '0;
            n--;
          end
        end
      end
      if (alloc_valid && alloc_ready && n < N) begin
        t[n] = alloc_pay;
        n++;
      end
    end
    qm   <= t;
    qcnt <= n;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue handshake monitor pops the scoreboard.
  always @(negedge clk) begin
    if (rst_aL === 1'b1 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL issue_unexpected: observed data %0h, expected no issue", issue_data);
      end
      if (exp_q.size() != 0) chk("issue_data", issue_data, exp_q.pop_front());
    end
  end

  task automatic idle();
    flush        = 1'b0;
    alloc_valid  = 1'b0;
    wakeup_valid = 2'b00;
    wakeup_tag   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_alloc(input logic [TW-1:0] t1, input logic r1, input logic [TW-1:0] t2,
                          input logic r2, input logic [EW-1:0] pay);
    alloc_valid    = 1'b1;
    alloc_src1_tag = t1;
    alloc_src1_rdy = r1;
    alloc_src2_tag = t2;
    alloc_src2_rdy = r2;
    alloc_pay      = pay;
  endtask

  initial begin
    rst_aL = 1'b0;
    idle();
    issue_ready    = 1'b1;
    alloc_src1_tag = '0;
    alloc_src2_tag = '0;
    alloc_src1_rdy = 1'b0;
    alloc_src2_rdy = 1'b0;
    alloc_pay      = '0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_deq_sel", 64'(deq_sel_onehot), 64'b0000);
    chk("rst_deq_ready", 64'(deq_ready), 64'd0);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    rst_aL = 1'b1;
    step();
    chk("post_rst_occupancy", 64'(occupancy), 64'd0);
    chk("post_rst_issue_valid", 64'(issue_valid), 64'd0);

    // Ready allocs: three fully ready entries issue in order through slot 0
    exp_q.push_back(64'hA0);
    exp_q.push_back(64'hA1);
    exp_q.push_back(64'hA2);
    do_alloc(6'd1, 1'b1, 6'd2, 1'b1, 64'hA0);
    step();
    chk("a_occ1", 64'(occupancy), 64'd1);
    do_alloc(6'd1, 1'b1, 6'd2, 1'b1, 64'hA1);
    #1;
    chk("a_sel_c1", 64'(deq_sel_onehot), 64'b0001);
    step();
    do_alloc(6'd1, 1'b1, 6'd2, 1'b1, 64'hA2);
    #1;
    chk("a_sel_c2", 64'(deq_sel_onehot), 64'b0001);
    chk("a_issue_valid", 64'(issue_valid), 64'd1);
    step();
    #1;
    chk("a_sel_c3", 64'(deq_sel_onehot), 64'b0001);
    step();
    #1;
    chk("a_sel_empty", 64'(deq_sel_onehot), 64'b0000);
    chk("a_occ0", 64'(occupancy), 64'd0);
    step();
    chk("a_issue_drained", 64'(issue_valid), 64'd0);

    // Wakeup: entry0 waits on tag 5, entry1 ready
    exp_q.push_back(64'hB1);
    exp_q.push_back(64'hB0);
    do_alloc(6'd5, 1'b0, 6'd0, 1'b1, 64'hB0);
    step();
    do_alloc(6'd3, 1'b1, 6'd4, 1'b1, 64'hB1);
    wakeup_valid = 2'b01;
    wakeup_tag   = {6'd0, 6'd6};
    #1;
    chk("b_sel_none", 64'(deq_sel_onehot), 64'b0000);
    step();
    #1;
    chk("b_sel_entry1", 64'(deq_sel_onehot), 64'b0010);
    step();
    wakeup_valid = 2'b01;
    wakeup_tag   = {6'd0, 6'd5};
    #1;
`ifdef IIQ_WAKEUP_BYPASS_EN
    chk("b_sel_wake_cycle", 64'(deq_sel_onehot), 64'b0001);
`else
    chk("b_sel_wake_cycle", 64'(deq_sel_onehot), 64'b0000);
`endif
    step();
    #1;
`ifdef IIQ_WAKEUP_BYPASS_EN
    chk("b_sel_after_wake", 64'(deq_sel_onehot), 64'b0000);
`else
    chk("b_sel_after_wake", 64'(deq_sel_onehot), 64'b0001);
`endif
    step();
    step();
    chk("b_occ0", 64'(occupancy), 64'd0);
    chk("b_issue_drained", 64'(issue_valid), 64'd0);

    // Backpressure and full-plus-dequeue
    exp_q.push_back(64'hC0);
    exp_q.push_back(64'hC2);
    exp_q.push_back(64'hC5);
    issue_ready = 1'b0;
    do_alloc(6'd1, 1'b1, 6'd2, 1'b1, 64'hC0);
    step();
    do_alloc(6'd7, 1'b0, 6'd0, 1'b1, 64'hC1);
    #1;
    chk("c_deq_ready_empty_issue", 64'(deq_ready), 64'd1);
    step();
    do_alloc(6'd1, 1'b1, 6'd2, 1'b1, 64'hC2);
    #1;
    chk("c_issue_valid", 64'(issue_valid), 64'd1);
    chk("c_deq_blocked", 64'(deq_ready), 64'd0);
    step();
    do_alloc(6'd8, 1'b0, 6'd0, 1'b1, 64'hC3);
    step();
    do_alloc(6'd0, 1'b1, 6'd9, 1'b0, 64'hC4);
    step();
    #1;
    chk("c_occ_full", 64'(occupancy), 64'd4);
    chk("c_alloc_ready_full", 64'(alloc_ready), 64'd0);
    chk("c_bp_deq_ready", 64'(deq_ready), 64'd0);
    chk("c_bp_sel", 64'(deq_sel_onehot), 64'b0000);
    chk("c_bp_data_held", issue_data, 64'hC0);
    step();
    chk("c_bp_data_held2", issue_data, 64'hC0);
    issue_ready = 1'b1;
    do_alloc(6'd1, 1'b1, 6'd2, 1'b1, 64'hC5);
    #1;
    chk("c_release_deq_ready", 64'(deq_ready), 64'd1);
    chk("c_release_sel", 64'(deq_sel_onehot), 64'b0010);
    chk("c_full_alloc_ready", 64'(alloc_ready), 64'd1);
    step();
    #1;
    chk("c_occ_stays_full", 64'(occupancy), 64'd4);
    chk("c_new_at_top", 64'(deq_sel_onehot), 64'b1000);
    step();

    // Flush with occupancy 3 and a valid issue; the concurrent alloc must be dropped
    chk("f_occ3", 64'(occupancy), 64'd3);
    chk("f_issue_valid", 64'(issue_valid), 64'd1);
    flush = 1'b1;
    do_alloc(6'd1, 1'b1, 6'd2, 1'b1, 64'hD0);
    #1;
    chk("f_deq_ready", 64'(deq_ready), 64'd0);
    step();
    #1;
    chk("f_occ0", 64'(occupancy), 64'd0);
    chk("f_issue_valid_clr", 64'(issue_valid), 64'd0);
    chk("f_sel", 64'(deq_sel_onehot), 64'b0000);
    chk("f_alloc_ready", 64'(alloc_ready), 64'd1);
    step();
    chk("f_occ_still0", 64'(occupancy), 64'd0);

    // Allocation woken by a same-cycle wakeup on port 1
    exp_q.push_back(64'hE0);
    do_alloc(6'd0, 1'b1, 6'd9, 1'b0, 64'hE0);
    wakeup_valid = 2'b10;
    wakeup_tag   = {6'd9, 6'd3};
    step();
    #1;
    chk("d_alloc_wake_sel", 64'(deq_sel_onehot), 64'b0001);
    step();
    chk("d_issue_valid", 64'(issue_valid), 64'd1);
    chk("d_occ0", 64'(occupancy), 64'd0);
    step();
    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
